// File: rtl/transfer_sequencer_pkg.sv
// Shared definitions for the transfer sequencer: opcodes, FSM states,
// control-register field positions and word-counter modes.
package transfer_sequencer_pkg;

  localparam logic [2:0] OP_LDCR = 3'b000;
  localparam logic [2:0] OP_RDST = 3'b001;
  localparam logic [2:0] OP_RDWC = 3'b010;
  localparam logic [2:0] OP_RDAC = 3'b011;
  localparam logic [2:0] OP_LDWC = 3'b100;
  localparam logic [2:0] OP_LDAC = 3'b101;
  localparam logic [2:0] OP_STEP = 3'b110;
  localparam logic [2:0] OP_RUN  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // CR[2] is the address direction, CR[1:0] the word-counter mode
  localparam int CR_DIR     = 2;
  localparam int CR_MODE_HI = 1;
  localparam int CR_MODE_LO = 0;

  localparam logic [1:0] WC_DOWN    = 2'b00;
  localparam logic [1:0] WC_UP_ZERO = 2'b01;
  localparam logic [1:0] WC_FROZEN  = 2'b10;
  localparam logic [1:0] WC_UP_LOAD = 2'b11;

  function automatic logic is_read_op(input logic [2:0] op);
    return (op == OP_RDST) || (op == OP_RDWC) || (op == OP_RDAC);
  endfunction

endpackage

// File: rtl/transfer_sequencer_updown_counter.sv
// Loadable up/down counter that wraps modulo 2^W. The wrap output flags that
// the count sits on the boundary for the current direction (all ones when
// counting up, zero when counting down), so an enabled step here wraps.
module updown_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  input  logic         up,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Load has priority over stepping; stepping wraps naturally in W bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= up ? (count + ONE) : (count - ONE);
    end
  end

  assign wrap = up ? (&count) : ~(|count);

endmodule

// File: rtl/transfer_sequencer.sv
// Opcode-driven memory transfer sequencer: an address counter (AC) and a word
// counter (WC) step on each acknowledged transfer, under a small IDLE/REQ/DONE
// state machine that runs single steps or bursts.
module transfer_sequencer
  import transfer_sequencer_pkg::*;
#(
  parameter int AW = 8,
  parameter int WW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [2:0]    I,
  input  logic          IVALID,
  output logic          IREADY,
  input  logic [DW-1:0] DIN,
  output logic [DW-1:0] DOUT,
  output logic          DVALID,
  output logic [AW-1:0] MADDR,
  output logic          MREQ,
  input  logic          MACK,
  input  logic          ABORT,
  output logic          BUSY,
  output logic          DONE,
  output logic          WRAP
);

  localparam logic [WW-1:0] WC_ONE = {{(WW-1){1'b0}}, 1'b1};

  state_t        state;
  state_t        state_next;
  logic [2:0]    cr;
  logic          wrap_flag;
  logic          run_mode;
  logic          abort_pending;
  logic [AW-1:0] ac;
  logic [WW-1:0] wc;
  logic          ac_wrap;
  logic          wc_wrap;
  logic [1:0]    wc_mode;
  logic          accept;
  logic          xfer;
  logic          ac_load;
  logic          wc_load;
  logic          wc_enable;
  logic          wc_up;
  logic          wc_last;
  logic [WW-1:0] wc_load_value;
  logic [DW-1:0] read_value;
  logic [DW-1:0] dout_reg;
  logic          dvalid_reg;

  assign IREADY = (state == S_IDLE);
  assign MREQ   = (state == S_REQ);
  assign DONE   = (state == S_DONE);
  assign BUSY   = (state == S_REQ) || (state == S_DONE);
  assign WRAP   = wrap_flag;
  assign MADDR  = ac;
  assign DOUT   = dout_reg;
  assign DVALID = dvalid_reg;

  assign wc_mode = cr[CR_MODE_HI:CR_MODE_LO];
  assign accept  = IVALID && IREADY;
  assign xfer    = (state == S_REQ) && MACK;

  assign ac_load       = accept && (I == OP_LDAC);
  assign wc_load       = accept && (I == OP_LDWC);
  assign wc_load_value = (wc_mode == WC_UP_ZERO) ? '0 : DIN[WW-1:0];
  assign wc_enable     = xfer && (wc_mode != WC_FROZEN);
  assign wc_up         = (wc_mode != WC_DOWN);
  assign wc_last       = (wc == WC_ONE);

  updown_counter #(.W(AW)) u_ac (
    .clk        (CLK),
    .rst_n      (RST_N),
    .load       (ac_load),
    .load_value (DIN[AW-1:0]),
    .enable     (xfer),
    .up         (~cr[CR_DIR]),
    .count      (ac),
    .wrap       (ac_wrap)
  );

  updown_counter #(.W(WW)) u_wc (
    .clk        (CLK),
    .rst_n      (RST_N),
    .load       (wc_load),
    .load_value (wc_load_value),
    .enable     (wc_enable),
    .up         (wc_up),
    .count      (wc),
    .wrap       (wc_wrap)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a burst ends on a down-count reaching zero or on an abort
  // seen at or before the acknowledge; an empty down-count burst skips REQ
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && (I == OP_STEP)) begin
          state_next = S_REQ;
        end else if (accept && (I == OP_RUN)) begin
          if ((wc_mode == WC_DOWN) && wc_wrap) begin
            state_next = S_DONE;
          end else begin
            state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (MACK) begin
          if (!run_mode || ABORT || abort_pending ||
              ((wc_mode == WC_DOWN) && wc_last)) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Control register, sticky wrap flag and burst bookkeeping
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cr            <= 3'b000;
      wrap_flag     <= 1'b0;
      run_mode      <= 1'b0;
      abort_pending <= 1'b0;
    end else begin
      if (accept && (I == OP_LDCR)) begin
        cr        <= DIN[2:0];
        wrap_flag <= 1'b0;
      end else if (xfer && ac_wrap) begin
        wrap_flag <= 1'b1;
      end
      if (accept && ((I == OP_STEP) || (I == OP_RUN))) begin
        run_mode      <= (I == OP_RUN);
        abort_pending <= 1'b0;
      end else if ((state == S_REQ) && ABORT && !MACK) begin
        abort_pending <= 1'b1;
      end
    end
  end

  // Read mux; status puts WRAP and BUSY at the top of the bus and CR at the bottom
  always_comb begin
    read_value = '0;
    case (I)
      OP_RDST: begin
        read_value[DW-1] = wrap_flag;
        read_value[DW-2] = BUSY;
        read_value[2:0]  = cr;
      end
      OP_RDWC: read_value[WW-1:0] = wc;
      OP_RDAC: read_value[AW-1:0] = ac;
      default: read_value = '0;
    endcase
  end

  // Read data is captured on acceptance and flagged valid for one cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout_reg   <= '0;
      dvalid_reg <= 1'b0;
    end else begin
      dvalid_reg <= accept && is_read_op(I);
      if (accept && is_read_op(I)) begin
        dout_reg <= read_value;
      end
    end
  end

endmodule
